// File: rtl/frame_wr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_wr_pkg
//  Description : Shared types and constants for the SDRAM frame write
//                scheduler (FSM state encoding, bank layout, burst length).
//  Revision    : 1.0 - initial release
// ============================================================================
package frame_wr_pkg;

    // Scheduler states; explicit 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ARMED  = 3'd2,
        ST_STREAM = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Default bank layout (WR1 side) and WR2 offset, in SDRAM words
    localparam int unsigned c_BANK_A_BASE = 32'h000000;
    localparam int unsigned c_BANK_B_BASE = 32'h100000;
    localparam int unsigned c_PORT2_OFS   = 32'h200000;
    localparam int unsigned c_BURST_LEN   = 128;

    // Start of frame: first valid pixel of row 0, column 0
    function automatic logic is_sof(input logic        dval,
                                    input logic [11:0] x,
                                    input logic [15:0] y);
        return dval && (x == 12'd0) && (y == 16'd0);
    endfunction

endpackage : frame_wr_pkg
`default_nettype wire

// File: rtl/sdram_wr_port.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_wr_port
//  Description : Output register stage for one SDRAM write-FIFO side: data,
//                write strobe, FIFO LOAD and the frame base/max addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_wr_port #(
    parameter int unsigned       ADDR_W    = 23,
    parameter int unsigned       BURST_LEN = 128,
    parameter logic [ADDR_W-1:0] RST_ADDR  = '0,
    parameter logic [ADDR_W-1:0] RST_MAX   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       i_data,
    input  logic              i_wr,
    input  logic              i_load,
    input  logic              i_addr_ld,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [ADDR_W-1:0] i_max_addr,
    output logic [15:0]       o_data,
    output logic              o_wr,
    output logic [7:0]        o_length,
    output logic              o_load,
    output logic [ADDR_W-1:0] o_addr,
    output logic [ADDR_W-1:0] o_max_addr
);

    logic [15:0]       r_data;
    logic              r_wr;
    logic              r_load;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_max_addr;

    // Register data/strobes every cycle; addresses only while being armed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data     <= '0;
            r_wr       <= 1'b0;
            r_load     <= 1'b0;
            r_addr     <= RST_ADDR;
            r_max_addr <= RST_MAX;
        end else begin
            r_data <= i_data;
            r_wr   <= i_wr;
            r_load <= i_load;
            if (i_addr_ld) begin
                r_addr     <= i_addr;
                r_max_addr <= i_max_addr;
            end
        end
    end

    assign o_data     = r_data;
    assign o_wr       = r_wr;
    assign o_load     = r_load;
    assign o_addr     = r_addr;
    assign o_max_addr = r_max_addr;
    assign o_length   = 8'(BURST_LEN);

endmodule : sdram_wr_port
`default_nettype wire

// File: rtl/frame_wr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : frame_wr_sched
//  Description : Frame-gated write scheduler feeding the two SDRAM write
//                FIFOs with ping-pong bank swapping after each whole frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_wr_sched
    import frame_wr_pkg::*;
#(
    parameter int unsigned ADDR_W      = 23,
    parameter int unsigned FRAME_WORDS = 307200,
    parameter int unsigned BANK_A_BASE = c_BANK_A_BASE,
    parameter int unsigned BANK_B_BASE = c_BANK_B_BASE,
    parameter int unsigned PORT2_OFS   = c_PORT2_OFS,
    parameter int unsigned LOAD_CYC    = 4,
    parameter int unsigned BURST_LEN   = c_BURST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iEN,
    input  logic [15:0]       iDATA_HI,
    input  logic [15:0]       iDATA_LO,
    input  logic              iDVAL,
    input  logic [11:0]       iX_Cont,
    input  logic [15:0]       iY_Cont,
    output logic [15:0]       WR1_DATA,
    output logic              WR1,
    output logic [ADDR_W-1:0] WR1_ADDR,
    output logic [ADDR_W-1:0] WR1_MAX_ADDR,
    output logic [7:0]        WR1_LENGTH,
    output logic              WR1_LOAD,
    output logic [15:0]       WR2_DATA,
    output logic              WR2,
    output logic [ADDR_W-1:0] WR2_ADDR,
    output logic [ADDR_W-1:0] WR2_MAX_ADDR,
    output logic [7:0]        WR2_LENGTH,
    output logic              WR2_LOAD,
    output logic              oRD_BANK,
    output logic              oFRAME_DONE,
    output logic              oSHORT,
    output logic              oBUSY
);

    localparam int unsigned CNT_W = $clog2(FRAME_WORDS + 1);
    localparam int unsigned LT_W  = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;

    localparam logic [CNT_W-1:0]  c_FRAME_LAST = CNT_W'(FRAME_WORDS);
    localparam logic [CNT_W-1:0]  c_CNT_ONE    = CNT_W'(1);
    localparam logic [LT_W-1:0]   c_LOAD_LAST  = LT_W'(LOAD_CYC - 1);
    localparam logic [ADDR_W-1:0] c_BASE_A     = ADDR_W'(BANK_A_BASE);
    localparam logic [ADDR_W-1:0] c_BASE_B     = ADDR_W'(BANK_B_BASE);
    localparam logic [ADDR_W-1:0] c_OFS2       = ADDR_W'(PORT2_OFS);
    localparam logic [ADDR_W-1:0] c_FWORDS     = ADDR_W'(FRAME_WORDS);

    state_t            r_state;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic              r_short;
    logic [CNT_W-1:0]  r_cnt;
    logic [LT_W-1:0]   r_load_cnt;

    logic              w_sof;
    logic              w_wr;
    logic              w_load;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [ADDR_W-1:0] w_base1;
    logic [ADDR_W-1:0] w_base2;

    // Write/LOAD requests and next addresses decoded from the current state
    always_comb begin
        w_sof     = is_sof(iDVAL, iX_Cont, iY_Cont);
        w_cnt_inc = r_cnt + 1'b1;
        w_wr      = ((r_state == ST_ARMED)  && iEN   && w_sof) ||
                    ((r_state == ST_STREAM) && iDVAL && !w_sof);
        w_load    = (r_state == ST_LOAD);
        w_base1   = r_wr_bank ? c_BASE_B : c_BASE_A;
        w_base2   = w_base1 + c_OFS2;
    end

    // Frame sequencer: arm FIFOs, gate whole frames, swap banks on completion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_short    <= 1'b0;
            r_cnt      <= '0;
            r_load_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (iEN) begin
                        r_load_cnt <= '0;
                        r_state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (r_load_cnt == c_LOAD_LAST) begin
                        r_state <= ST_ARMED;
                    end else begin
                        r_load_cnt <= r_load_cnt + 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (!iEN) begin
                        r_state <= ST_IDLE;
                    end else if (w_sof) begin
                        r_cnt   <= c_CNT_ONE;
                        r_state <= (c_CNT_ONE == c_FRAME_LAST) ? ST_DONE : ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (iDVAL) begin
                        if (w_sof) begin
                            // Early start of frame: abandon this bank fill and re-arm
                            r_short    <= 1'b1;
                            r_cnt      <= '0;
                            r_load_cnt <= '0;
                            r_state    <= ST_LOAD;
                        end else begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == c_FRAME_LAST) begin
                                r_state <= ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    r_rd_bank  <= r_wr_bank;
                    r_wr_bank  <= ~r_wr_bank;
                    r_cnt      <= '0;
                    r_load_cnt <= '0;
                    r_state    <= iEN ? ST_LOAD : ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign oRD_BANK    = r_rd_bank;
    assign oSHORT      = r_short;
    assign oBUSY       = (r_state != ST_IDLE);
    assign oFRAME_DONE = (r_state == ST_DONE);

    sdram_wr_port #(
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN),
        .RST_ADDR  (c_BASE_A),
        .RST_MAX   (c_BASE_A + c_FWORDS)
    ) u_port1 (
        .clk        (clk),
        .rst        (rst),
        .i_data     (iDATA_HI),
        .i_wr       (w_wr),
        .i_load     (w_load),
        .i_addr_ld  (w_load),
        .i_addr     (w_base1),
        .i_max_addr (w_base1 + c_FWORDS),
        .o_data     (WR1_DATA),
        .o_wr       (WR1),
        .o_length   (WR1_LENGTH),
        .o_load     (WR1_LOAD),
        .o_addr     (WR1_ADDR),
        .o_max_addr (WR1_MAX_ADDR)
    );

    sdram_wr_port #(
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN),
        .RST_ADDR  (c_BASE_A + c_OFS2),
        .RST_MAX   (c_BASE_A + c_OFS2 + c_FWORDS)
    ) u_port2 (
        .clk        (clk),
        .rst        (rst),
        .i_data     (iDATA_LO),
        .i_wr       (w_wr),
        .i_load     (w_load),
        .i_addr_ld  (w_load),
        .i_addr     (w_base2),
        .i_max_addr (w_base2 + c_FWORDS),
        .o_data     (WR2_DATA),
        .o_wr       (WR2),
        .o_length   (WR2_LENGTH),
        .o_load     (WR2_LOAD),
        .o_addr     (WR2_ADDR),
        .o_max_addr (WR2_MAX_ADDR)
    );

endmodule : frame_wr_sched
`default_nettype wire

// File: tb/tb_frame_wr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_wr_sched
//  Description : Self-checking bench for frame_wr_sched (16-word frames,
//                4-cycle LOAD). Expected writes are queued when pixels are
//                driven and popped when the write strobes appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_wr_sched;

    localparam int unsigned ADDR_W = 23;

    logic              clk = 1'b0;
    logic              rst;
    logic              iEN;
    logic [15:0]       iDATA_HI;
    logic [15:0]       iDATA_LO;
    logic              iDVAL;
    logic [11:0]       iX_Cont;
    logic [15:0]       iY_Cont;
    logic [15:0]       WR1_DATA, WR2_DATA;
    logic              WR1, WR2, WR1_LOAD, WR2_LOAD;
    logic [ADDR_W-1:0] WR1_ADDR, WR1_MAX_ADDR, WR2_ADDR, WR2_MAX_ADDR;
    logic [7:0]        WR1_LENGTH, WR2_LENGTH;
    logic              oRD_BANK, oFRAME_DONE, oSHORT, oBUSY;

    frame_wr_sched #(
        .ADDR_W      (ADDR_W),
        .FRAME_WORDS (16),
        .LOAD_CYC    (4)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .iEN          (iEN),
        .iDATA_HI     (iDATA_HI),
        .iDATA_LO     (iDATA_LO),
        .iDVAL        (iDVAL),
        .iX_Cont      (iX_Cont),
        .iY_Cont      (iY_Cont),
        .WR1_DATA     (WR1_DATA),
        .WR1          (WR1),
        .WR1_ADDR     (WR1_ADDR),
        .WR1_MAX_ADDR (WR1_MAX_ADDR),
        .WR1_LENGTH   (WR1_LENGTH),
        .WR1_LOAD     (WR1_LOAD),
        .WR2_DATA     (WR2_DATA),
        .WR2          (WR2),
        .WR2_ADDR     (WR2_ADDR),
        .WR2_MAX_ADDR (WR2_MAX_ADDR),
        .WR2_LENGTH   (WR2_LENGTH),
        .WR2_LOAD     (WR2_LOAD),
        .oRD_BANK     (oRD_BANK),
        .oFRAME_DONE  (oFRAME_DONE),
        .oSHORT       (oSHORT),
        .oBUSY        (oBUSY)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] hi;
        logic [15:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   wr_seen   = 0;
    int   load_seen = 0;
    int   done_seen = 0;
    int   w0, d0, l0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Output monitor: count LOAD cycles and frame pulses, check every write
    always @(negedge clk) begin
        if (WR1_LOAD === 1'b1) load_seen++;
        if (WR1_LOAD === 1'b1 || WR2_LOAD === 1'b1) chk("load_pair", {WR1_LOAD, WR2_LOAD}, 2'b11);
        if (oFRAME_DONE === 1'b1) done_seen++;
        if (WR1 === 1'b1 || WR2 === 1'b1) begin
            wr_seen++;
            chk("wr_pair", {WR1, WR2}, 2'b11);
            if (sb.size() == 0) begin
                chk("wr_unexpected", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("wr1_data", WR1_DATA, mon_e.hi);
                chk("wr2_data", WR2_DATA, mon_e.lo);
                chk("wr_latency", cyc, mon_e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pix(input int x, input int y, input bit expw);
        logic [15:0] h;
        logic [15:0] l;
        h        = 16'($urandom);
        l        = 16'($urandom);
        iDVAL    = 1'b1;
        iX_Cont  = 12'(x);
        iY_Cont  = 16'(y);
        iDATA_HI = h;
        iDATA_LO = l;
        if (expw) sb.push_back('{h, l, cyc + 1});
        tick();
        iDVAL = 1'b0;
    endtask

    task automatic frame(input int n, input bit expw);
        for (int i = 0; i < n; i++) pix(i, 0, expw);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; iEN = 1'b0; iDVAL = 1'b0;
        iDATA_HI = '0; iDATA_LO = '0; iX_Cont = '0; iY_Cont = '0;
        idle(3);
        // Reset state
        chk("rst_wr1", WR1, 0);
        chk("rst_wr2", WR2, 0);
        chk("rst_load", WR1_LOAD, 0);
        chk("rst_rd_bank", oRD_BANK, 0);
        chk("rst_wr1_addr", WR1_ADDR, 32'h0);
        chk("rst_wr2_addr", WR2_ADDR, 32'h200000);
        chk("rst_wr1_max", WR1_MAX_ADDR, 32'h10);
        chk("rst_wr2_max", WR2_MAX_ADDR, 32'h200010);
        chk("rst_len1", WR1_LENGTH, 128);
        chk("rst_len2", WR2_LENGTH, 128);
        chk("rst_busy", oBUSY, 0);
        chk("rst_done", oFRAME_DONE, 0);
        chk("rst_short", oSHORT, 0);
        rst = 1'b0;
        idle(1);

        // Arm: LOAD exactly 4 cycles, then one full frame into bank 0
        l0 = load_seen;
        iEN = 1'b1;
        idle(1);
        chk("busy_load", oBUSY, 1);
        idle(8);
        chk("load_cycles", load_seen - l0, 4);
        chk("b0_wr1_addr", WR1_ADDR, 32'h0);
        chk("b0_wr2_addr", WR2_ADDR, 32'h200000);
        w0 = wr_seen; d0 = done_seen;
        frame(16, 1);
        idle(2);
        chk("f1_writes", wr_seen - w0, 16);
        chk("f1_done", done_seen - d0, 1);
        chk("f1_rd_bank", oRD_BANK, 0);
        idle(6);
        chk("b1_wr1_addr", WR1_ADDR, 32'h100000);
        chk("b1_wr2_addr", WR2_ADDR, 32'h300000);
        chk("b1_wr1_max", WR1_MAX_ADDR, 32'h100010);
        chk("b1_wr2_max", WR2_MAX_ADDR, 32'h300010);

        // Non-SOF pixel while armed is dropped; then a frame into bank 1
        w0 = wr_seen; d0 = done_seen;
        pix(5, 3, 0);
        idle(2);
        chk("armed_drop", wr_seen - w0, 0);
        frame(16, 1);
        idle(2);
        chk("f2_done", done_seen - d0, 1);
        chk("f2_rd_bank", oRD_BANK, 1);
        idle(6);
        chk("b0_again_addr", WR1_ADDR, 32'h0);

        // Early SOF after 10 pixels: short flag, LOAD replays, same bank
        d0 = done_seen; l0 = load_seen;
        frame(10, 1);
        pix(0, 0, 0);
        idle(8);
        chk("short_flag", oSHORT, 1);
        chk("short_reload", load_seen - l0, 4);
        chk("short_addr", WR1_ADDR, 32'h0);
        chk("short_no_done", done_seen - d0, 0);
        frame(16, 1);
        idle(2);
        chk("f3_done", done_seen - d0, 1);
        chk("f3_rd_bank", oRD_BANK, 0);
        idle(6);
        chk("f3_next_addr", WR1_ADDR, 32'h100000);

        // Enable dropped mid-frame: frame completes, then idle
        w0 = wr_seen; d0 = done_seen;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) iEN = 1'b0;
            pix(i, 0, 1);
        end
        idle(3);
        chk("f4_writes", wr_seen - w0, 16);
        chk("f4_done", done_seen - d0, 1);
        chk("f4_busy", oBUSY, 0);
        chk("f4_rd_bank", oRD_BANK, 1);

        // Restart from idle, fill bank 0, then reset partway into bank 1
        iEN = 1'b1;
        idle(8);
        chk("f5_addr", WR1_ADDR, 32'h0);
        frame(16, 1);
        idle(8);
        chk("f6_addr", WR1_ADDR, 32'h100000);
        for (int i = 0; i < 7; i++) pix(i, 0, 1);
        rst = 1'b1;
        pix(7, 0, 0);
        chk("rst_mid_wr1", WR1, 0);
        chk("rst_mid_rd_bank", oRD_BANK, 0);
        chk("rst_mid_short", oSHORT, 0);
        idle(1);
        rst = 1'b0;
        idle(8);
        chk("rearm_addr", WR1_ADDR, 32'h0);
        chk("rearm_busy", oBUSY, 1);
        d0 = done_seen;
        frame(16, 1);
        idle(2);
        chk("f7_done", done_seen - d0, 1);
        chk("f7_rd_bank", oRD_BANK, 0);
        idle(6);
        chk("f7_next_addr", WR1_ADDR, 32'h100000);

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_frame_wr_sched
`default_nettype wire
